// File: rtl/irqctl.sv
// irqctl: interrupt controller with per-source sync, edge/level mode, mask, pending, force and priority vector
module irqctl #(
    parameter int NUM_SRC     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               wr,
    input  logic [2:0]         addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               wt,
    input  logic [NUM_SRC-1:0] src,
    output logic [NUM_SRC-1:0] irq,
    output logic               irq_any
);
    localparam logic [31:0] VALID = 32'((64'd1 << NUM_SRC) - 64'd1);
    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0] s, s_d;
    logic [31:0] pending, mask, mode, active, pend_nx, wd, set_w, clr_w, rd_data, data_q;
    logic [4:0] vec_idx;
    logic wr_go, cap;
    assign s       = sync_q[SYNC_STAGES-1];
    assign wd      = data_in & VALID;
    assign active  = pending & mask;
    assign irq     = active[NUM_SRC-1:0];
    assign irq_any = |active;
    assign data_out = data_q;
    // source synchronisers plus delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sync_q <= '0;
            s_d    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src};
            s_d    <= s;
        end
    // bus FSM state register; reset drops any access in flight
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    // every access is one wait cycle then one ack cycle
    always_comb state_nx = (state == IDLE && en) ? ACK : IDLE;
    // bus outputs: wait on first cycle, read capture on entry to ACK, write commit at end of ACK
    always_comb begin
        wt    = en && state == IDLE;
        cap   = wt;
        wr_go = en && wr && state == ACK;
    end
    // pending next state: edge bits latch with set winning over W1C, level bits follow s
    always_comb begin
        set_w   = 32'(s & ~s_d) | ((wr_go && addr == 3'd5) ? wd : '0);
        clr_w   = (wr_go && addr == 3'd0) ? wd : '0;
        pend_nx = ((mode & ((pending & ~clr_w) | set_w)) | (~mode & 32'(s))) & VALID;
    end
    // highest-numbered active source wins the vector
    always_comb begin
        vec_idx = '0;
        for (int i = 0; i < 32; i++)
            if (active[i]) vec_idx = 5'(i);
    end
    // read mux sampled from current register state when the access starts
    always_comb
        rd_data = addr == 3'd0 ? pending :
                  addr == 3'd1 ? mask :
                  addr == 3'd2 ? mode :
                  addr == 3'd3 ? active :
                  addr == 3'd4 ? (irq_any ? 32'(vec_idx) : 32'h8000_0000) : '0;
    // control registers and captured read data
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pending <= '0;
            mask    <= '0;
            mode    <= '0;
            data_q  <= '0;
        end else begin
            pending <= pend_nx;
            if (wr_go && addr == 3'd1) mask <= wd;
            if (wr_go && addr == 3'd2) mode <= wd;
            if (cap) data_q <= rd_data;
        end
endmodule

// File: tb/tb_irqctl.sv
// tb_irqctl: directed-vector bench for irqctl (NUM_SRC=16, SYNC_STAGES=2)
module tb_irqctl;
    logic clk = 0, reset_n = 0, en = 0, wr = 0;
    logic [2:0] addr = 0;
    logic [31:0] data_in = 0, data_out, d;
    logic wt, irq_any;
    logic [15:0] src = 16'hFFFF, irq;
    int n_vec = 0, n_bad = 0;

    irqctl #(.NUM_SRC(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .wt(wt),
        .src(src), .irq(irq), .irq_any(irq_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] q);
        @(negedge clk);
        en = 1; wr = 0; addr = a;
        #1 chk("rd_wt_hi", 32'(wt), 1);
        @(negedge clk);
        chk("rd_wt_lo", 32'(wt), 0);
        q = data_out;
        en = 0;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        en = 1; wr = 1; addr = a; data_in = v;
        #1 chk("wr_wt_hi", 32'(wt), 1);
        @(negedge clk);
        chk("wr_wt_lo", 32'(wt), 0);
        @(negedge clk);
        en = 0; wr = 0;
    endtask

    initial begin
        // reset with all sources high
        #1 chk("rst_irq", 32'(irq), 0);
        chk("rst_any", 32'(irq_any), 0);
        en = 1;
        #1 chk("rst_wt", 32'(wt), 1);
        en = 0;
        @(negedge clk) reset_n = 1;
        bus_rd(3'd0, d); chk("pend_early", d, 0);
        repeat (2) @(negedge clk);
        bus_rd(3'd0, d); chk("pend_lvl", d, 32'h0000FFFF);
        src = 0;
        repeat (4) @(negedge clk);
        // edge latch and W1C on source 8
        bus_wr(3'd2, 32'h0100);
        bus_wr(3'd1, 32'h0100);
        src[8] = 1;
        repeat (2) @(posedge clk);
        #1 chk("irq8_e2", 32'(irq), 0);
        @(posedge clk);
        #1 chk("irq8_e3", 32'(irq), 32'h0100);
        chk("any_e3", 32'(irq_any), 1);
        @(negedge clk) src[8] = 0;
        repeat (4) @(negedge clk);
        chk("irq8_hold", 32'(irq), 32'h0100);
        bus_rd(3'd0, d); chk("pend8_once", d, 32'h0100);
        bus_rd(3'd4, d); chk("vec8", d, 32'h8);
        bus_wr(3'd0, 32'h0100);
        chk("irq8_clr", 32'(irq), 0);
        // rising edge and W1C of bit 4 on the same edge
        bus_wr(3'd2, 32'h0010);
        src[4] = 1;
        bus_wr(3'd0, 32'h0010);
        bus_rd(3'd0, d); chk("set_wins", d, 32'h0010);
        src[4] = 0;
        repeat (3) @(negedge clk);
        bus_wr(3'd0, 32'h0010);
        bus_rd(3'd0, d); chk("w1c4", d, 0);
        // priority vector
        bus_wr(3'd2, 32'hFFFF);
        bus_wr(3'd5, 32'hC011);
        bus_wr(3'd1, 32'h4011);
        bus_rd(3'd3, d); chk("active", d, 32'h4011);
        chk("irq_pri", 32'(irq), 32'h4011);
        bus_rd(3'd4, d); chk("vec14", d, 32'd14);
        bus_wr(3'd0, 32'h4000);
        bus_rd(3'd4, d); chk("vec4", d, 32'd4);
        bus_wr(3'd1, 32'h0);
        bus_rd(3'd4, d); chk("vec_none", d, 32'h8000_0000);
        chk("any_none", 32'(irq_any), 0);
        bus_rd(3'd0, d); chk("mask_keeps_pend", d, 32'h8011);
        bus_wr(3'd0, 32'hFFFF);
        // level mode ignores W1C and FORCE
        bus_wr(3'd2, 32'h0);
        src[3] = 1;
        repeat (4) @(negedge clk);
        bus_rd(3'd0, d); chk("lvl_set", d, 32'h8);
        bus_wr(3'd0, 32'h8);
        bus_wr(3'd5, 32'h4);
        bus_rd(3'd0, d); chk("lvl_sw", d, 32'h8);
        bus_wr(3'd2, 32'h8);
        bus_rd(3'd0, d); chk("lvl2edge", d, 32'h8);
        bus_wr(3'd0, 32'h8);
        bus_rd(3'd0, d); chk("no_spur", d, 0);
        bus_wr(3'd2, 32'h0);
        repeat (2) @(negedge clk);
        bus_rd(3'd0, d); chk("edge2lvl", d, 32'h8);
        src[3] = 0;
        bus_rd(3'd0, d); chk("lvl_hold", d, 32'h8);
        bus_rd(3'd0, d); chk("lvl_fall", d, 0);
        // bus corner cases
        bus_wr(3'd1, 32'hFFFF_FFFF);
        bus_rd(3'd1, d); chk("mask_width", d, 32'h0000FFFF);
        bus_wr(3'd6, 32'hDEAD_BEEF);
        bus_rd(3'd6, d); chk("addr6", d, 0);
        bus_rd(3'd5, d); chk("force_rd", d, 0);
        bus_wr(3'd1, 32'h0);
        @(negedge clk);
        en = 1; wr = 1; addr = 3'd1; data_in = 32'h55;
        @(negedge clk);
        en = 0; wr = 0;
        repeat (2) @(negedge clk);
        bus_rd(3'd1, d); chk("abort", d, 0);
        bus_wr(3'd1, 32'hFF00);
        @(negedge clk);
        en = 1; wr = 1; addr = 3'd1; data_in = 32'h1234;
        @(posedge clk);
        #2 reset_n = 0;
        #1 chk("rst_mid_wt", 32'(wt), 1);
        @(negedge clk);
        en = 0; wr = 0; reset_n = 1;
        bus_rd(3'd1, d); chk("rst_mid_mask", d, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
